psum_accumulator: RTL

- Sits directly downstream of the systolic array in the router/sequential datapath.
- Captures each PE row's partial sum and accumulates it across routing passes (weight-reuse/reroute iterations) in a bank of saturating accumulators.
- On request, drains the bank serially: requantizes each value to DATA_WIDTH with rounding shift, optional ReLU and saturation, and emits it with an output-SRAM write address over a valid/ready handshake.

---
 rtl/psum_accumulator.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Captures one partial sum per PE row from the systolic array and accumulates
//   them across routing passes in a bank of saturating accumulators. On a flush
//   request the bank is drained serially: each accumulator is requantized
//   (rounding right shift, optional ReLU, saturation to DATA_WIDTH) and emitted
//   with an output-SRAM write address over a valid/ready handshake.
//
// Ports
//   i_clk            clock, rising edge
//   i_nrst           asynchronous active-low reset
//   i_reg_clear      synchronous clear (highest priority after reset)
//   i_en             enables accept of i_psum_valid / i_flush while accumulating
//   i_psum_valid     i_psum carries one partial sum per row
//   i_psum           row r at [r*PSUM_WIDTH +: PSUM_WIDTH], signed
//   i_first          with i_psum_valid: load instead of add
//   i_flush          request drain of all ROWS accumulators
//   i_shift          requant right shift, sampled on flush
//   i_relu_en        ReLU enable, sampled on flush
//   i_out_base_addr  first write address, sampled on flush
//   o_data/o_addr    requantized word and its SRAM address
//   o_valid/i_ready  output handshake
//   o_busy           high while draining
//   o_done           one-cycle pulse after the last word is accepted
//   o_overflow       sticky accumulator saturation flag
module psum_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 24,
  parameter int ROWS       = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  logic                       i_reg_clear,
  input  logic                       i_en,
  input  logic                       i_psum_valid,
  input  logic [ROWS*PSUM_WIDTH-1:0] i_psum,
  input  logic                       i_first,
  input  logic                       i_flush,
  input  logic [4:0]                 i_shift,
  input  logic                       i_relu_en,
  input  logic [ADDR_WIDTH-1:0]      i_out_base_addr,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic [ADDR_WIDTH-1:0]      o_addr,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_overflow
);

  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic signed [PSUM_WIDTH-1:0] ACC_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic signed [PSUM_WIDTH-1:0] ACC_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};

  // Requant limits expressed at the widened (PSUM_WIDTH+1) working width.
  localparam logic signed [PSUM_WIDTH:0] Q_MAX = (PSUM_WIDTH+1)'((2**(DATA_WIDTH-1)) - 1);
  localparam logic signed [PSUM_WIDTH:0] Q_MIN = -Q_MAX - (PSUM_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic        [IDX_W-1:0]       idx_q, idx_d;
  logic signed [PSUM_WIDTH-1:0]  acc_q [ROWS];
  logic signed [PSUM_WIDTH-1:0]  acc_d [ROWS];
  logic        [4:0]             shift_q, shift_d;
  logic                          relu_q, relu_d;
  logic        [ADDR_WIDTH-1:0]  base_q, base_d;
  logic        [DATA_WIDTH-1:0]  data_q, data_d;
  logic        [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                          ovf_q, ovf_d;

  logic                          accept;
  logic signed [PSUM_WIDTH-1:0]  sel_acc;

  // Rounding right shift, optional ReLU, then saturation to DATA_WIDTH.
  // The rounding add is done one bit wider than the accumulator.
  function automatic logic [DATA_WIDTH-1:0] requant(
    input logic signed [PSUM_WIDTH-1:0] a,
    input logic        [4:0]            sh,
    input logic                         relu
  );
    logic signed [PSUM_WIDTH:0] ext;
    logic signed [PSUM_WIDTH:0] rnd;
    logic signed [PSUM_WIDTH:0] v;
    ext = {a[PSUM_WIDTH-1], a};
    if (sh != 5'd0) begin
      rnd = $signed((PSUM_WIDTH+1)'(1) << (sh - 5'd1));
      v   = (ext + rnd) >>> sh;
    end else begin
      v = ext;
    end
    if (relu && v[PSUM_WIDTH]) begin
      v = '0;
    end
    if (v > Q_MAX) begin
      v = Q_MAX;
    end else if (v < Q_MIN) begin
      v = Q_MIN;
    end
    return v[DATA_WIDTH-1:0];
  endfunction

  assign accept = (state_q == ST_ACCUM) && i_en;

  // Accumulator bank update with saturation and overflow detection.
  always_comb begin
    logic signed [PSUM_WIDTH-1:0] p;
    logic signed [PSUM_WIDTH:0]   sum;
    ovf_d = ovf_q;
    for (int unsigned r = 0; r < ROWS; r++) begin
      acc_d[r] = acc_q[r];
      p        = i_psum[r*PSUM_WIDTH +: PSUM_WIDTH];
      sum      = {acc_q[r][PSUM_WIDTH-1], acc_q[r]} + {p[PSUM_WIDTH-1], p};
      if (accept && i_psum_valid) begin
        if (i_first) begin
          acc_d[r] = p;
        end else if (sum[PSUM_WIDTH] != sum[PSUM_WIDTH-1]) begin
          // Sign of the widened sum tells which rail was crossed.
          acc_d[r] = sum[PSUM_WIDTH] ? ACC_MIN : ACC_MAX;
          ovf_d    = 1'b1;
        end else begin
          acc_d[r] = sum[PSUM_WIDTH-1:0];
        end
      end
    end
  end

  // Control FSM and drain sequencing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    relu_d  = relu_q;
    base_d  = base_q;
    unique case (state_q)
      ST_ACCUM: begin
        if (accept && i_flush) begin
          state_d = ST_DRAIN;
          idx_d   = '0;
          shift_d = i_shift;
          relu_d  = i_relu_en;
          base_d  = i_out_base_addr;
        end
      end
      ST_DRAIN: begin
        if (i_ready) begin
          if (idx_q == IDX_W'(ROWS - 1)) begin
            state_d = ST_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_ACCUM;
      end
      default: begin
        state_d = ST_ACCUM;
        idx_d   = '0;
      end
    endcase
  end

  // The output word is computed from next-state values so that it is already
  // registered in the first DRAIN cycle, including any same-cycle psum update
  // and the freshly latched shift/relu/base. While stalled, idx_d == idx_q and
  // the accumulators are frozen, so the word is naturally held.
  always_comb begin
    sel_acc = acc_d[idx_d];
    data_d  = '0;
    addr_d  = '0;
    if (state_d == ST_DRAIN) begin
      data_d = requant(sel_acc, shift_d, relu_d);
      addr_d = base_d + ADDR_WIDTH'(idx_d);
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= ST_ACCUM;
      idx_q   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      base_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned r = 0; r < ROWS; r++) begin
        acc_q[r] <= '0;
      end
    end else if (i_reg_clear) begin
      state_q <= ST_ACCUM;
      idx_q   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      base_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned r = 0; r < ROWS; r++) begin
        acc_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      relu_q  <= relu_d;
      base_q  <= base_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
      for (int unsigned r = 0; r < ROWS; r++) begin
        acc_q[r] <= acc_d[r];
      end
    end
  end

  assign o_data     = data_q;
  assign o_addr     = addr_q;
  assign o_valid    = (state_q == ST_DRAIN);
  assign o_busy     = (state_q == ST_DRAIN);
  assign o_done     = (state_q == ST_DONE);
  assign o_overflow = ovf_q;

endmodule
